// File: rtl/slew_limiter.sv
// rtl/slew_limiter.sv - four-channel slew-rate limiter with one shared time-multiplexed datapath
//
// Purpose:
//   Limits how far each of four calibrated sample channels may move per sample
//   period. Upward moves are capped at rise_step and downward moves at
//   fall_step. A step of 0 turns limiting off in that direction. A single
//   subtract/compare datapath is shared by the channels. After each rising
//   edge of sample_clk an FSM walks it across the channels, one per clk, and
//   then commits all four results at once.
//
// Optional feature:
//   SLEW_LIMITER_EXP_EN - the effective step becomes (|diff| >> EXP_SHIFT)
//   plus the programmed step, clamped to |diff|. This gives an
//   exponential-plus-linear approach. A programmed step of 0 still bypasses
//   limiting. When the macro is undefined, stepping is purely linear, and
//   neither the shifter nor EXP_SHIFT exists.
//
// Ports:
//   clk             system clock
//   rst_n           asynchronous active-low reset
//   sample_clk      codec sample clock (level); a rising edge marks new samples
//   rise_step       unsigned max upward change per sample (0 = no limit)
//   fall_step       unsigned max downward change per sample (0 = no limit)
//   sample_in0..3   signed input samples
//   sample_out0..3  signed slewed outputs, registered, updated together
//   out_valid       one-clk pulse coincident with a sample_out0..3 update
module slew_limiter #(
  parameter int W = 16
`ifdef SLEW_LIMITER_EXP_EN
  , parameter int EXP_SHIFT = 4
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_clk,
  input  logic        [W-1:0] rise_step,
  input  logic        [W-1:0] fall_step,
  input  logic signed [W-1:0] sample_in0,
  input  logic signed [W-1:0] sample_in1,
  input  logic signed [W-1:0] sample_in2,
  input  logic signed [W-1:0] sample_in3,
  output logic signed [W-1:0] sample_out0,
  output logic signed [W-1:0] sample_out1,
  output logic signed [W-1:0] sample_out2,
  output logic signed [W-1:0] sample_out3,
  output logic                out_valid
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CH0    = 3'd1,
    S_CH1    = 3'd2,
    S_CH2    = 3'd3,
    S_CH3    = 3'd4,
    S_COMMIT = 3'd5
  } state_e;

  state_e state_q, state_d;
  logic   sclk_q;
  logic   pending_q, pending_d;
  logic   sclk_rise;

  // FSM-decoded controls
  logic       ch_active;
  logic [1:0] ch_sel;
  logic       commit;

  // Per-channel running state and the shared datapath signals
  logic [W-1:0] chan_q [4];
  logic [W-1:0] cur_in;
  logic [W-1:0] cur_st;
  logic signed [W:0] diff;
  logic [W:0]   abs_diff;
  logic         diff_pos;
  logic         diff_neg;
  logic [W-1:0] step;
  logic [W:0]   eff_step;
  logic         limited;
  logic [W-1:0] next_st;

  // sample_clk is compared against its own one-clk-old copy
  assign sclk_rise = ~sclk_q & sample_clk;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      sclk_q    <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sclk_q    <= sample_clk;
      pending_q <= pending_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // An edge seen outside IDLE is remembered in pending. Any number of such
  // edges collapse into one. In IDLE, a live edge and a pending edge start the
  // same single pass, so a request is never lost when it arrives together with
  // the return to IDLE.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    case (state_q)
      S_IDLE: begin
        if (sclk_rise || pending_q) begin
          state_d   = S_CH0;
          pending_d = 1'b0;
        end
      end
      S_CH0:    state_d = S_CH1;
      S_CH1:    state_d = S_CH2;
      S_CH2:    state_d = S_CH3;
      S_CH3:    state_d = S_COMMIT;
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (state_q != S_IDLE && sclk_rise) begin
      pending_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    ch_active = 1'b0;
    ch_sel    = 2'd0;
    commit    = 1'b0;
    case (state_q)
      S_CH0:    begin ch_active = 1'b1; ch_sel = 2'd0; end
      S_CH1:    begin ch_active = 1'b1; ch_sel = 2'd1; end
      S_CH2:    begin ch_active = 1'b1; ch_sel = 2'd2; end
      S_CH3:    begin ch_active = 1'b1; ch_sel = 2'd3; end
      S_COMMIT: commit = 1'b1;
      default:  ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Shared datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    cur_in = sample_in0;
    case (ch_sel)
      2'd0:    cur_in = sample_in0;
      2'd1:    cur_in = sample_in1;
      2'd2:    cur_in = sample_in2;
      default: cur_in = sample_in3;
    endcase
  end

  assign cur_st = chan_q[ch_sel];

  // The subtraction uses one extra bit, so full-scale swings cannot overflow
  assign diff     = $signed({cur_in[W-1], cur_in}) - $signed({cur_st[W-1], cur_st});
  assign diff_neg = diff[W];
  assign diff_pos = ~diff[W] & (diff != '0);
  assign abs_diff = diff_neg ? $unsigned(-diff) : $unsigned(diff);
  assign step     = diff_pos ? rise_step : fall_step;

`ifdef SLEW_LIMITER_EXP_EN
  // Proportional term plus the linear floor. abs_diff is at most 2^W-1 and
  // step is below 2^W, so the W+1-bit sum does not overflow.
  assign eff_step = (abs_diff >> EXP_SHIFT) + {1'b0, step};
`else
  assign eff_step = {1'b0, step};
`endif

  // A zero step bypasses the limit. A step that reaches the input lands on it
  // exactly, so the result never overshoots.
  assign limited = (step != '0) && (eff_step < abs_diff);

  // When limited, eff_step < |diff|. The result therefore lies strictly
  // between the old state and the input, which means W-bit wrap-around
  // arithmetic gives the exact value and no saturation is needed.
  always_comb begin
    next_st = cur_in;
    if (limited) begin
      next_st = diff_pos ? (cur_st + eff_step[W-1:0]) : (cur_st - eff_step[W-1:0]);
    end
  end

  // ---------------------------------------------------------------------------
  // Channel state registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        chan_q[i] <= '0;
      end
    end else if (ch_active) begin
      chan_q[ch_sel] <= next_st;
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers: all four channels change on the same edge as out_valid
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_out0 <= '0;
      sample_out1 <= '0;
      sample_out2 <= '0;
      sample_out3 <= '0;
      out_valid   <= 1'b0;
    end else begin
      out_valid <= commit;
      if (commit) begin
        sample_out0 <= chan_q[0];
        sample_out1 <= chan_q[1];
        sample_out2 <= chan_q[2];
        sample_out3 <= chan_q[3];
      end
    end
  end

endmodule
